// File: rtl/spi_word_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_word_packer_fifo
// Description : Packs SPI bytes MSB-first into words; command bytes flush and
//               become tagged single entries; results go through an FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_word_packer_fifo #(
    parameter int BYTE_W         = 8,
    parameter int BYTES_PER_WORD = 2,
    parameter int DEPTH          = 160,
    parameter int WORD_W         = BYTE_W * BYTES_PER_WORD,
    parameter int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk_SPI,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_cmd,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_mode,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   level,
    output logic              partial
);

    localparam int                ASM_W     = (BYTES_PER_WORD - 1) * BYTE_W;
    localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W:0]   mem [DEPTH];

    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic              w_full;
    logic              w_partial;
    logic              w_accept;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic [WORD_W:0]   w_wdata;
    logic [WORD_W:0]   w_head;

    always_comb begin
        w_full    = (count_q == FULL_CNT);
        w_partial = (byte_cnt_q != '0);
        s_ready   = !w_full && !clear && !(s_cmd && w_partial);
        w_accept  = s_valid && s_ready;
        // A command meeting a partial word emits the partial word instead of
        // being accepted; it is taken on a later cycle.
        w_flush   = s_valid && s_cmd && w_partial && !w_full && !clear;
        w_pop     = (count_q != '0) && m_ready && !clear;

        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        w_push     = 1'b0;
        w_wdata    = '0;

        if (w_flush) begin
            w_push     = 1'b1;
            w_wdata    = {1'b0, asm_q, {BYTE_W{1'b0}}};
            byte_cnt_d = '0;
            asm_d      = '0;
        end else if (w_accept) begin
            if (s_cmd) begin
                w_push  = 1'b1;
                w_wdata = {1'b1, s_data, {(WORD_W - BYTE_W){1'b0}}};
            end else if (byte_cnt_q == LAST_SLOT) begin
                w_push     = 1'b1;
                w_wdata    = {1'b0, asm_q, s_data};
                byte_cnt_d = '0;
                asm_d      = '0;
            end else begin
                for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                    if (byte_cnt_q == CNT_W'(k)) begin
                        asm_d[ASM_W-1-k*BYTE_W -: BYTE_W] = s_data;
                    end
                end
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (clear) begin
            byte_cnt_d = '0;
            asm_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk_SPI or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_SPI) begin
        if (w_push) begin
            mem[wr_ptr_q] <= w_wdata;
        end
    end

    assign w_head  = mem[rd_ptr_q];
    assign m_data  = w_head[WORD_W-1:0];
    assign m_mode  = w_head[WORD_W];
    assign m_valid = (count_q != '0);
    assign level   = count_q;
    assign partial = w_partial;

endmodule
`default_nettype wire
